// File: rtl/ram32k_arbiter.sv
// rtl/ram32k_arbiter.sv - two-master round-robin arbiter with burst limit for the 32K x 16 data RAM
module ram32k_arbiter #(
    parameter int AW        = 15,
    parameter int DW        = 16,
    parameter int BURST_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_in,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;

    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ptr;
    logic       ptr_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic       own_req;
    logic       other_req;
    logic       sel1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        own_req   = 1'b0;
        other_req = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = ptr ? G1 : G0;
                end else if (req0) begin
                    state_nxt = G0;
                end else if (req1) begin
                    state_nxt = G1;
                end
            end
            G0, G1: begin
                own_req   = (state == G1) ? req1 : req0;
                other_req = (state == G1) ? req0 : req1;
                // Stay only if the burst limit is not hit while the other side waits.
                if (own_req && !(other_req && cnt == CNT_LAST)) begin
                    cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + 4'd1;
                end else begin
                    cnt_nxt   = 4'd0;
                    ptr_nxt   = (state == G0);
                    state_nxt = other_req ? ((state == G0) ? G1 : G0) : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grants come from the state register only; reset masks them immediately.
    assign gnt0 = (state == G0) && !reset;
    assign gnt1 = (state == G1) && !reset;

    assign sel1        = (state == G1);
    assign ram_address = sel1 ? addr1 : addr0;
    assign ram_in      = sel1 ? wdata1 : wdata0;
    assign ram_load    = sel1 ? (gnt1 && req1 && we1) : (gnt0 && req0 && we0);

    assign rdata0 = ram_out;
    assign rdata1 = ram_out;

endmodule

// File: tb/tb_ram32k_arbiter.sv
// tb/tb_ram32k_arbiter.sv - directed self-checking bench for ram32k_arbiter with a behavioural RAM
module tb_ram32k_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [14:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [15:0] rdata0, rdata1;
    logic [14:0] ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    logic [15:0] mem [0:32767];
    logic        pre_we;
    logic [14:0] pre_addr;
    logic [15:0] pre_data;

    int n_checks;
    int n_fail;

    ram32k_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign ram_out = mem[ram_address];

    always @(posedge clock) begin
        if (ram_load)
            mem[ram_address] <= ram_in;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        next_cycle();
        pre_we   = 1'b0;
    endtask

    task automatic do_reset;
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    int exp_c[10];
    int exp_l[9];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        preload(15'h0100, 16'hA100);
        preload(15'h0200, 16'hB200);
        preload(15'h0050, 16'h5555);

        // Reset held two cycles with both masters requesting.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1;
        addr0 = 15'h0010; wdata0 = 16'h1111; addr1 = 15'h0020;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rst_gnt0", gnt0, 0);
            check("rst_gnt1", gnt1, 0);
            check("rst_load", ram_load, 0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_idle_gnt0", gnt0, 0);
        next_cycle();
        @(negedge clock);
        check("post_rst_gnt0", gnt0, 1);
        check("post_rst_gnt1", gnt1, 0);
        we0 = 1'b0;
        do_reset();

        // Single master 1 write then read of the top word.
        req1 = 1'b1; we1 = 1'b1; addr1 = 15'h7FFF; wdata1 = 16'hBEEF;
        @(negedge clock);
        check("m1_idle_gnt1", gnt1, 0);
        check("m1_idle_load", ram_load, 0);
        next_cycle();
        @(negedge clock);
        check("m1_wr_gnt1", gnt1, 1);
        check("m1_wr_load", ram_load, 1);
        check("m1_wr_addr", ram_address, 15'h7FFF);
        check("m1_wr_data", ram_in, 16'hBEEF);
        next_cycle();
        we1 = 1'b0;
        @(negedge clock);
        check("m1_rd_gnt1", gnt1, 1);
        check("m1_rd_load", ram_load, 0);
        check("m1_rd_data", rdata1, 16'hBEEF);
        next_cycle();
        req1 = 1'b0;
        @(negedge clock);
        check("m1_drop_load", ram_load, 0);
        next_cycle();
        @(negedge clock);
        check("m1_idle_after", gnt1, 0);
        do_reset();

        // Continuous contention: 4 for master 0, 4 for master 1, back to 0.
        exp_c = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1};
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 15'h0100; addr1 = 15'h0200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("cont_gnt0_%0d", i), gnt0, exp_c[i] == 1);
            check($sformatf("cont_gnt1_%0d", i), gnt1, exp_c[i] == 2);
            check($sformatf("cont_addr_%0d", i), ram_address, (exp_c[i] == 2) ? 15'h0200 : 15'h0100);
            if (exp_c[i] == 1) check($sformatf("cont_rd0_%0d", i), rdata0, 16'hA100);
            if (exp_c[i] == 2) check($sformatf("cont_rd1_%0d", i), rdata1, 16'hB200);
            next_cycle();
        end
        do_reset();

        // Master 0 alone saturates its count, then a late competitor arrives.
        exp_l = '{0, 1, 1, 1, 1, 1, 1, 1, 2};
        req0 = 1'b1; req1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            check($sformatf("lone_gnt0_%0d", i), gnt0, exp_l[i] == 1);
            check($sformatf("lone_gnt1_%0d", i), gnt1, exp_l[i] == 2);
            next_cycle();
            if (i == 6) req1 = 1'b1;
        end
        do_reset();

        // Release to idle moves the pointer to master 1.
        req0 = 1'b1;
        next_cycle();
        @(negedge clock);
        check("rel_g0", gnt0, 1);
        next_cycle();
        req0 = 1'b0;
        @(negedge clock);
        check("rel_g0_hold", gnt0, 1);
        next_cycle();
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clock);
        check("rel_idle_gnt0", gnt0, 0);
        check("rel_idle_gnt1", gnt1, 0);
        next_cycle();
        @(negedge clock);
        check("rel_ptr1_gnt1", gnt1, 1);
        check("rel_ptr1_gnt0", gnt0, 0);
        do_reset();

        // Reset lands in the middle of a master 1 write burst.
        req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0040; wdata1 = 16'h4444;
        next_cycle();
        @(negedge clock);
        check("mid_first_load", ram_load, 1);
        next_cycle();
        addr1 = 15'h0050; wdata1 = 16'hDEAD; reset = 1'b1;
        @(negedge clock);
        check("mid_rst_load", ram_load, 0);
        check("mid_rst_gnt1", gnt1, 0);
        next_cycle();
        reset = 1'b0; req1 = 1'b0; we1 = 1'b0;
        check("mid_old_kept", mem[15'h0050], 16'h5555);
        check("mid_first_wr", mem[15'h0040], 16'h4444);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clock);
        check("mid_idle_gnt0", gnt0, 0);
        check("mid_idle_gnt1", gnt1, 0);
        next_cycle();
        @(negedge clock);
        check("mid_ptr0_gnt0", gnt0, 1);
        check("mid_ptr0_gnt1", gnt1, 0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
